// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-channel registered round-robin mux with valid/ready per channel.
// Define RR_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_mux_arbiter #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_last,
  output logic [N-1:0]  in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [SW-1:0] out_sel,
  output logic [N-1:0]  grant,
  input  logic          out_ready
);
  logic          valid_q, valid_d, last_q, last_d, load_en, xfer, pick_vld;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] sel_q, sel_d, ptr_q, ptr_d, pick, nxt, cand;
  logic [SW:0]   sum;
  logic [N-1:0]  grant_q, grant_d;
`ifdef RR_MUX_LOCK_EN
  logic          lock_q, lock_d;
`endif
  // Scan from the far end back toward ptr so the closest valid channel wins.
  always_comb begin
    pick = '0;
    pick_vld = 1'b0;
    sum = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (SW + 1)'(k);
      cand = (sum >= (SW + 1)'(N)) ? SW'(sum - (SW + 1)'(N)) : sum[SW-1:0];
      if (in_valid[cand]) begin
        pick = cand;
        pick_vld = 1'b1;
      end
    end
`ifdef RR_MUX_LOCK_EN
    if (lock_q) begin
      pick = sel_q;
      pick_vld = in_valid[sel_q];
    end
`endif
  end
  assign load_en  = !valid_q || out_ready;
  assign xfer     = load_en && pick_vld;
  assign in_ready = xfer ? N'(1) << pick : '0;
  assign nxt      = (pick == SW'(N - 1)) ? '0 : pick + 1'b1;
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef RR_MUX_LOCK_EN
    lock_d  = lock_q;
`endif
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = in_data[pick*W +: W];
      last_d  = in_last[pick];
      sel_d   = pick;
      grant_d = N'(1) << pick;
`ifdef RR_MUX_LOCK_EN
      lock_d  = !in_last[pick];
      ptr_d   = in_last[pick] ? nxt : ptr_q;
`else
      ptr_d   = nxt;
`endif
    end else if (out_ready) begin
      valid_d = 1'b0;
      grant_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
`ifdef RR_MUX_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef RR_MUX_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;
  assign grant     = grant_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of an 8-channel and a 5-channel instance.
module tb_rr_mux_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0]  v8, l8, rdy8, g8, od8;
  logic [63:0] d8;
  logic        ov8, ol8, or8;
  logic [2:0]  os8;
  logic [4:0]  v5, l5, rdy5, g5;
  logic [39:0] d5;
  logic [7:0]  od5;
  logic        ov5, ol5, or5;
  logic [2:0]  os5;
  int n_cmp = 0, n_bad = 0;

  rr_mux_arbiter #(.N(8), .W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_data(d8), .in_last(l8),
    .in_ready(rdy8), .out_valid(ov8), .out_data(od8), .out_last(ol8),
    .out_sel(os8), .grant(g8), .out_ready(or8));
  rr_mux_arbiter #(.N(5), .W(8)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_data(d5), .in_last(l5),
    .in_ready(rdy5), .out_valid(ov5), .out_data(od5), .out_last(ol5),
    .out_sel(os5), .grant(g5), .out_ready(or5));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; v8 = '0; v5 = '0; or8 = 1'b1; or5 = 1'b1; l8 = 8'hFF; l5 = 5'h1F;
    for (int i = 0; i < 8; i++) d8[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'(8'h10 + i);
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL reset_ov8 c%0d got %b want 0", c, ov8); end
      n_cmp++; if (g8 !== 8'h00) begin n_bad++; $display("FAIL reset_g8 c%0d got %h want 00", c, g8); end
      n_cmp++; if (rdy8 !== 8'h00) begin n_bad++; $display("FAIL reset_rdy8 c%0d got %h want 00", c, rdy8); end
      n_cmp++; if (os8 !== 3'd0 || od8 !== 8'h00) begin n_bad++; $display("FAIL reset_sel8 c%0d got %0d/%h want 0/00", c, os8, od8); end
      n_cmp++; if (ov5 !== 1'b0 || rdy5 !== 5'h00) begin n_bad++; $display("FAIL reset_u5 c%0d got %b/%h want 0/00", c, ov5, rdy5); end
      step();
    end
  endtask

  task automatic test_round_robin8;
    v8 = 8'hFF;
    #1;
    n_cmp++; if (rdy8 !== 8'h01) begin n_bad++; $display("FAIL rr8_rdy0 got %h want 01", rdy8); end
    for (int k = 0; k < 9; k++) begin
      step();
      n_cmp++; if (os8 !== 3'(k % 8)) begin n_bad++; $display("FAIL rr8_sel k%0d got %0d want %0d", k, os8, k % 8); end
      n_cmp++; if (od8 !== 8'(k % 8)) begin n_bad++; $display("FAIL rr8_data k%0d got %h want %h", k, od8, k % 8); end
      n_cmp++; if (g8 !== 8'(1 << (k % 8)) || ov8 !== 1'b1) begin n_bad++; $display("FAIL rr8_grant k%0d got %h/%b want %h/1", k, g8, ov8, 1 << (k % 8)); end
    end
    v8 = '0;
    step();
    n_cmp++; if (ov8 !== 1'b0 || g8 !== 8'h00) begin n_bad++; $display("FAIL rr8_drain got %b/%h want 0/00", ov8, g8); end
    n_cmp++; if (od8 !== 8'h00 || os8 !== 3'd0) begin n_bad++; $display("FAIL rr8_hold got %h/%0d want 00/0", od8, os8); end
  endtask

  task automatic test_wrap5;
    int exp_sel[4] = '{4, 0, 4, 0};
    v5 = 5'b01000;
    step();
    n_cmp++; if (os5 !== 3'd3 || od5 !== 8'h13) begin n_bad++; $display("FAIL wrap5_pre got %0d/%h want 3/13", os5, od5); end
    v5 = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (os5 !== 3'(exp_sel[k])) begin n_bad++; $display("FAIL wrap5_sel k%0d got %0d want %0d", k, os5, exp_sel[k]); end
      n_cmp++; if (g5 !== 5'(1 << exp_sel[k]) || od5 !== 8'(8'h10 + exp_sel[k])) begin n_bad++; $display("FAIL wrap5_out k%0d got %h/%h want %h/%h", k, g5, od5, 1 << exp_sel[k], 8'h10 + exp_sel[k]); end
    end
    v5 = '0;
    step();
  endtask

  task automatic test_stall;
    v8 = 8'hFF; or8 = 1'b1;
    step();
    n_cmp++; if (os8 !== 3'd1) begin n_bad++; $display("FAIL stall_first got %0d want 1", os8); end
    or8 = 1'b0;
    #1;
    n_cmp++; if (rdy8 !== 8'h00) begin n_bad++; $display("FAIL stall_rdy got %h want 00", rdy8); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (os8 !== 3'd1 || od8 !== 8'h01) begin n_bad++; $display("FAIL stall_hold c%0d got %0d/%h want 1/01", c, os8, od8); end
      n_cmp++; if (g8 !== 8'h02 || ov8 !== 1'b1) begin n_bad++; $display("FAIL stall_grant c%0d got %h/%b want 02/1", c, g8, ov8); end
      n_cmp++; if (rdy8 !== 8'h00) begin n_bad++; $display("FAIL stall_rdy c%0d got %h want 00", c, rdy8); end
    end
    or8 = 1'b1;
    #1;
    n_cmp++; if (rdy8 !== 8'h04) begin n_bad++; $display("FAIL stall_release_rdy got %h want 04", rdy8); end
    step();
    n_cmp++; if (os8 !== 3'd2 || od8 !== 8'h02) begin n_bad++; $display("FAIL stall_release got %0d/%h want 2/02", os8, od8); end
    v8 = '0;
    step();
  endtask

  task automatic test_packet_lock;
`ifdef RR_MUX_LOCK_EN
    int exp_sel[5] = '{2, 2, 2, 3, 0};
    int n_exp = 4;
`else
    int exp_sel[5] = '{2, 3, 2, 3, 2};
    int n_exp = 5;
`endif
    int c2 = 0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    v8 = 8'b0000_1100; l8 = 8'hFF;
    for (int k = 0; k < n_exp; k++) begin
      l8[2] = (c2 == 2);
      step();
      n_cmp++; if (os8 !== 3'(exp_sel[k])) begin n_bad++; $display("FAIL lock_sel k%0d got %0d want %0d", k, os8, exp_sel[k]); end
      n_cmp++; if (ol8 !== ((exp_sel[k] == 2) ? (c2 == 2) : 1'b1)) begin n_bad++; $display("FAIL lock_last k%0d got %b", k, ol8); end
      if (exp_sel[k] == 2) c2++;
    end
    v8 = '0; l8 = 8'hFF;
    step();
  endtask

  task automatic test_async_reset;
    v8 = 8'h20; or8 = 1'b1;
    step();
    n_cmp++; if (os8 !== 3'd5) begin n_bad++; $display("FAIL arst_pre got %0d want 5", os8); end
    v8 = '0; or8 = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ov8 !== 1'b0 || g8 !== 8'h00) begin n_bad++; $display("FAIL arst_now got %b/%h want 0/00", ov8, g8); end
    n_cmp++; if (os8 !== 3'd0 || od8 !== 8'h00) begin n_bad++; $display("FAIL arst_regs got %0d/%h want 0/00", os8, od8); end
    rst_n = 1'b1;
    v8 = 8'h50; or8 = 1'b1;
    step();
    n_cmp++; if (os8 !== 3'd4 || g8 !== 8'h10) begin n_bad++; $display("FAIL arst_first got %0d/%h want 4/10", os8, g8); end
    v8 = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin8();
    test_wrap5();
    test_stall();
    test_packet_lock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
